// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types for the dual-port memory controller
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

endpackage

// File: rtl/mem_dp_ctrl_if.sv
// rtl/mem_dp_ctrl_if.sv - port-1 requester bus between compute/load units and the controller
interface mem_dp_ctrl_if #(
    parameter int NREQ    = 2,
    parameter int MEMSIZE = 8,
    parameter int DWIDTH  = 16
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         req_we;
    logic [NREQ*MEMSIZE-1:0] req_addr;
    logic [NREQ*DWIDTH-1:0]  req_wdata;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         rd_valid;
    logic [DWIDTH-1:0]       rd_data;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rd_valid, rd_data
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant with next-pointer output
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PTRW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PTRW-1:0] ptr_nxt
);

    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        // search starts at ptr and wraps; first hit wins
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                ptr_nxt  = PTRW'((idx + 1) % NREQ);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_dp_ctrl.sv
// rtl/mem_dp_ctrl.sv - port-1 arbitration/read routing and port-2 scan engine for mem_dp
module mem_dp_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int MEMSIZE = 8,
    parameter int NREQ    = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_dp_ctrl_if.slave       rq,
    input  logic               scan_start,
    input  logic [MEMSIZE-1:0] scan_base,
    input  logic [MEMSIZE:0]   scan_len,
    output logic               scan_valid,
    output logic [DWIDTH-1:0]  scan_data,
    output logic               scan_busy,
    output logic               scan_done,
    output logic               mem_we1,
    output logic [MEMSIZE-1:0] mem_addr1,
    output logic [DWIDTH-1:0]  mem_wdata1,
    input  logic [DWIDTH-1:0]  mem_rdata1,
    output logic               mem_we2,
    output logic [MEMSIZE-1:0] mem_addr2,
    output logic [DWIDTH-1:0]  mem_wdata2,
    input  logic [DWIDTH-1:0]  mem_rdata2
);

    localparam int PTRW = $clog2(NREQ);

    logic [PTRW-1:0] ptr;
    logic [PTRW-1:0] ptr_nxt;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rd_valid_q;

    rr_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) u_arb (
        .req     (rq.req),
        .ptr     (ptr),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            rd_valid_q <= '0;
        end else begin
            if (|gnt) ptr <= ptr_nxt;
            rd_valid_q <= gnt & ~rq.req_we;
        end
    end

    always_comb begin
        mem_we1    = 1'b0;
        mem_addr1  = '0;
        mem_wdata1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mem_we1    = rq.req_we[i];
                mem_addr1  = rq.req_addr[i*MEMSIZE +: MEMSIZE];
                mem_wdata1 = rq.req_wdata[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign rq.gnt      = gnt;
    assign rq.rd_valid = rd_valid_q;
    assign rq.rd_data  = mem_rdata1;

    scan_state_t        state;
    scan_state_t        state_nxt;
    logic [MEMSIZE-1:0] addr;
    logic [MEMSIZE:0]   cnt;
    logic               valid_q;
    logic               zero_done_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (scan_start && (scan_len != '0)) state_nxt = RUN;
            RUN:     if (cnt == (MEMSIZE+1)'(1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            cnt         <= '0;
            valid_q     <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            valid_q     <= (state == RUN);
            // an empty scan still completes, one cycle after the start
            zero_done_q <= (state == IDLE) && scan_start && (scan_len == '0);
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        addr <= scan_base;
                        cnt  <= scan_len;
                    end
                end
                RUN: begin
                    addr <= addr + MEMSIZE'(1);
                    cnt  <= cnt - (MEMSIZE+1)'(1);
                end
                default: ;
            endcase
        end
    end

    // DRAIN coincides with the last word's valid cycle
    assign scan_busy  = (state != IDLE);
    assign scan_done  = (state == DRAIN) || zero_done_q;
    assign scan_valid = valid_q;
    assign scan_data  = mem_rdata2;
    assign mem_addr2  = (state == RUN) ? addr : '0;
    assign mem_we2    = 1'b0;
    assign mem_wdata2 = '0;

endmodule

// File: tb/tb_mem_dp_ctrl.sv
// tb/tb_mem_dp_ctrl.sv - self-checking bench for mem_dp_ctrl with a behavioural memory and controller model
module tb_mem_dp_ctrl;

    localparam int DW = 16;
    localparam int MS = 8;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_dp_ctrl_if #(.NREQ(NR), .MEMSIZE(MS), .DWIDTH(DW)) rq ();

    logic          scan_start = 1'b0;
    logic [MS-1:0] scan_base  = '0;
    logic [MS:0]   scan_len   = '0;
    logic          scan_valid, scan_busy, scan_done;
    logic [DW-1:0] scan_data;
    logic          mem_we1, mem_we2;
    logic [MS-1:0] mem_addr1, mem_addr2;
    logic [DW-1:0] mem_wdata1, mem_wdata2, mem_rdata1, mem_rdata2;

    mem_dp_ctrl #(.DWIDTH(DW), .MEMSIZE(MS), .NREQ(NR)) dut (
        .clk(clk), .rst(rst), .rq(rq.slave),
        .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
        .scan_valid(scan_valid), .scan_data(scan_data), .scan_busy(scan_busy), .scan_done(scan_done),
        .mem_we1(mem_we1), .mem_addr1(mem_addr1), .mem_wdata1(mem_wdata1), .mem_rdata1(mem_rdata1),
        .mem_we2(mem_we2), .mem_addr2(mem_addr2), .mem_wdata2(mem_wdata2), .mem_rdata2(mem_rdata2)
    );

    // memory instance: registered address, combinational array read
    logic [DW-1:0] mem [0:255];
    logic [MS-1:0] a1q = '0;
    logic [MS-1:0] a2q = '0;
    always @(posedge clk) begin
        if (mem_we1) mem[mem_addr1] <= mem_wdata1;
        a1q <= mem_addr1;
        a2q <= mem_addr2;
    end
    assign mem_rdata1 = mem[a1q];
    assign mem_rdata2 = mem[a2q];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // model state
    logic [DW-1:0] ref_mem [0:255];
    int            m_last      = NR - 1;
    logic [NR-1:0] m_rdv       = '0;
    logic [MS-1:0] m_rd_addr   = '0;
    int            m_left      = 0;
    logic [MS-1:0] m_next      = '0;
    logic          m_drain     = 1'b0;
    logic          m_prev_iss  = 1'b0;
    logic [MS-1:0] m_prev_addr = '0;
    logic          m_zero      = 1'b0;

    function automatic logic [NR-1:0] exp_gnt_f(input logic [NR-1:0] r, input int last);
        logic [NR-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < NR; k++) begin
            idx = (last + 1 + k) % NR;
            if (r[idx] && g == '0) g[idx] = 1'b1;
        end
        return g;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'(i);
            ref_mem[i] = DW'(i);
        end
    end

    initial forever begin
        logic [NR-1:0] g;
        logic          idle;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_last = NR - 1; m_rdv = '0; m_left = 0; m_drain = 1'b0;
            m_prev_iss = 1'b0; m_zero = 1'b0; m_next = '0;
        end else begin
            g = exp_gnt_f(rq.req, m_last);
            m_rdv = '0;
            for (int i = 0; i < NR; i++) begin
                if (g[i]) begin
                    m_last = i;
                    if (rq.req_we[i]) ref_mem[rq.req_addr[i*MS +: MS]] = rq.req_wdata[i*DW +: DW];
                    else begin
                        m_rdv[i]  = 1'b1;
                        m_rd_addr = rq.req_addr[i*MS +: MS];
                    end
                end
            end
            idle        = (m_left == 0) && !m_drain;
            m_prev_iss  = (m_left > 0);
            m_prev_addr = m_next;
            if (m_left > 0) begin
                m_next  = m_next + MS'(1);
                m_left  = m_left - 1;
                m_drain = (m_left == 0);
            end else begin
                m_drain = 1'b0;
            end
            m_zero = idle && scan_start && (scan_len == 0);
            if (idle && scan_start && scan_len != 0) begin
                m_left = int'(scan_len);
                m_next = scan_base;
            end
        end
    end

    initial forever begin
        logic [NR-1:0] eg;
        logic          ewe;
        logic [MS-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        eg = exp_gnt_f(rq.req, m_last);
        ewe = 1'b0; ea = '0; ed = '0;
        for (int i = 0; i < NR; i++) begin
            if (eg[i]) begin
                ewe = rq.req_we[i];
                ea  = rq.req_addr[i*MS +: MS];
                ed  = rq.req_wdata[i*DW +: DW];
            end
        end
        chk("gnt", 32'(rq.gnt), 32'(eg));
        chk("mem_we1", 32'(mem_we1), 32'(ewe));
        chk("mem_addr1", 32'(mem_addr1), 32'(ea));
        chk("mem_wdata1", 32'(mem_wdata1), 32'(ed));
        chk("rd_valid", 32'(rq.rd_valid), 32'(m_rdv));
        if (m_rdv != '0) chk("rd_data", 32'(rq.rd_data), 32'(ref_mem[m_rd_addr]));
        chk("scan_busy", 32'(scan_busy), 32'((m_left > 0) || m_drain));
        chk("scan_valid", 32'(scan_valid), 32'(m_prev_iss));
        if (m_prev_iss) chk("scan_data", 32'(scan_data), 32'(ref_mem[m_prev_addr]));
        chk("scan_done", 32'(scan_done), 32'(m_drain || m_zero));
        chk("mem_addr2", 32'(mem_addr2), 32'((m_left > 0) ? m_next : MS'(0)));
        chk("mem_we2", 32'(mem_we2), 32'(0));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [NR-1:0] r, input logic [NR-1:0] we,
                           input logic [MS-1:0] a0, input logic [DW-1:0] d0,
                           input logic [MS-1:0] a1, input logic [DW-1:0] d1);
        rq.req       = r;
        rq.req_we    = we;
        rq.req_addr  = {a1, a0};
        rq.req_wdata = {d1, d0};
    endtask

    // runs a scan and returns what it produced over a fixed window
    task automatic run_scan(input logic [MS-1:0] base, input logic [MS:0] len, input int window,
                            output int busy_n, output int done_n, output int valid_n,
                            output logic [DW-1:0] words [8], output logic done_on_last);
        busy_n = 0; done_n = 0; valid_n = 0; done_on_last = 1'b0;
        for (int i = 0; i < 8; i++) words[i] = '0;
        scan_base = base; scan_len = len; scan_start = 1'b1;
        cyc();
        scan_start = 1'b0;
        for (int c = 0; c < window; c++) begin
            @(negedge clk);
            if (scan_busy) busy_n++;
            if (scan_done) begin
                done_n++;
                done_on_last = scan_valid && (valid_n == int'(len) - 1);
            end
            if (scan_valid) begin
                if (valid_n < 8) words[valid_n] = scan_data;
                valid_n++;
            end
            cyc();
        end
    endtask

    initial begin
        logic [NR-1:0] gseq [4];
        logic [DW-1:0] w [8];
        int bn, dn, vn, dcnt;
        logic dl;
        gseq[0] = 2'b01; gseq[1] = 2'b10; gseq[2] = 2'b01; gseq[3] = 2'b10;

        set_req('0, '0, '0, '0, '0, '0);
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("reset rd_valid", 32'(rq.rd_valid), 32'(0));
        chk("reset scan_busy", 32'(scan_busy), 32'(0));
        cyc();

        set_req(2'b11, 2'b00, 8'h00, 16'h0, 8'h01, 16'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rr gnt[%0d]", k), 32'(rq.gnt), 32'(gseq[k]));
            cyc();
        end

        set_req(2'b01, 2'b01, 8'h05, 16'h1234, 8'h00, 16'h0);
        cyc();
        set_req(2'b10, 2'b00, 8'h00, 16'h0, 8'h05, 16'h0);
        cyc();
        set_req('0, '0, '0, '0, '0, '0);
        @(negedge clk);
        chk("wr-rd rd_valid", 32'(rq.rd_valid), 32'(2'b10));
        chk("wr-rd rd_data", 32'(rq.rd_data), 32'h1234);
        cyc();

        run_scan(8'hFE, 9'd4, 7, bn, dn, vn, w, dl);
        chk("wrap busy cycles", 32'(bn), 32'd5);
        chk("wrap valid count", 32'(vn), 32'd4);
        chk("wrap done count", 32'(dn), 32'd1);
        chk("wrap done on last", 32'(dl), 32'd1);
        chk("wrap word0", 32'(w[0]), 32'h00FE);
        chk("wrap word1", 32'(w[1]), 32'h00FF);
        chk("wrap word2", 32'(w[2]), 32'h0000);
        chk("wrap word3", 32'(w[3]), 32'h0001);

        scan_base = 8'h0E; scan_len = 9'd4; scan_start = 1'b1;
        cyc();
        scan_start = 1'b0;
        cyc();
        cyc();
        set_req(2'b01, 2'b01, 8'h10, 16'h00AA, 8'h00, 16'h0);
        @(negedge clk);
        chk("bypass mem_addr2", 32'(mem_addr2), 32'h10);
        cyc();
        set_req('0, '0, '0, '0, '0, '0);
        @(negedge clk);
        chk("bypass scan_data", 32'(scan_data), 32'h00AA);
        repeat (3) cyc();

        scan_len = 9'd0; scan_start = 1'b1;
        cyc();
        scan_start = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("len0 done", 32'(scan_done), 32'd1);
                chk("len0 busy", 32'(scan_busy), 32'd0);
                chk("len0 valid", 32'(scan_valid), 32'd0);
            end
            if (scan_done) dcnt++;
            cyc();
        end
        chk("len0 done count", 32'(dcnt), 32'd1);

        scan_base = 8'h20; scan_len = 9'd8; scan_start = 1'b1;
        cyc();
        scan_start = 1'b0;
        cyc();
        cyc();
        set_req(2'b01, 2'b00, 8'h30, 16'h0, 8'h00, 16'h0);
        cyc();
        set_req('0, '0, '0, '0, '0, '0);
        chk("pre-rst rd_valid", 32'(rq.rd_valid), 32'(2'b01));
        chk("pre-rst scan_valid", 32'(scan_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst scan_valid", 32'(scan_valid), 32'd0);
        chk("rst scan_busy", 32'(scan_busy), 32'd0);
        chk("rst rd_valid", 32'(rq.rd_valid), 32'd0);
        dcnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (scan_done) dcnt++;
        end
        chk("rst no done", 32'(dcnt), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        run_scan(8'h40, 9'd3, 6, bn, dn, vn, w, dl);
        chk("post-rst valid count", 32'(vn), 32'd3);
        chk("post-rst done count", 32'(dn), 32'd1);
        chk("post-rst word0", 32'(w[0]), 32'h0040);
        chk("post-rst word2", 32'(w[2]), 32'h0042);

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
